// File: rtl/key_scan.sv
// key_scan: 4x4 active-low keypad scanner with per-frame debouncing.
// Drives one row low per slot, samples synchronised columns on the last
// cycle of each slot, and debounces whole-frame results in a small FSM.
module key_scan #(
    parameter int unsigned SCAN_DIV        = 4096,
    parameter int unsigned DEBOUNCE_FRAMES = 3
) (
    input  logic       clk,
    input  logic       sysclr_n,
    input  logic [3:0] KEY_COL_n,
    output logic [3:0] KEY_ROW_n,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);

    localparam int unsigned SLOT_W = $clog2(SCAN_DIV);
    localparam int unsigned CNT_W  = $clog2(DEBOUNCE_FRAMES + 1);
    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(DEBOUNCE_FRAMES - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DEBOUNCE,
        ST_PRESSED,
        ST_RELEASE
    } state_t;

    logic [3:0]        col_meta;
    logic [3:0]        col_sync;
    logic [SLOT_W-1:0] slot_cnt;
    logic [1:0]        row_idx;
    logic              slot_end;
    logic              frame_end;

    logic [2:0]        row_count;
    logic [1:0]        row_col;
    logic [2:0]        sum_count;
    logic [1:0]        frame_n;
    logic [3:0]        frame_code;
    logic [1:0]        acc_n;
    logic [3:0]        acc_code;

    state_t            state, state_nx;
    logic [CNT_W-1:0]  cnt, cnt_nx;
    logic [3:0]        cand, cand_nx;
    logic [3:0]        code_nx;
    logic              valid_nx;
    logic              held_nx;

    // Two-flop synchroniser for the asynchronous column lines
    always_ff @(posedge clk or negedge sysclr_n) begin
        if (!sysclr_n) begin
            col_meta <= '1;
            col_sync <= '1;
        end else begin
            col_meta <= KEY_COL_n;
            col_sync <= col_meta;
        end
    end

    assign slot_end  = (slot_cnt == SLOT_LAST);
    assign frame_end = slot_end && (row_idx == 2'd3);

    // Slot timer and one-hot-low row rotation
    always_ff @(posedge clk or negedge sysclr_n) begin
        if (!sysclr_n) begin
            slot_cnt  <= '0;
            row_idx   <= '0;
            KEY_ROW_n <= 4'b1110;
        end else if (slot_end) begin
            slot_cnt  <= '0;
            row_idx   <= row_idx + 2'd1;
            KEY_ROW_n <= {KEY_ROW_n[2:0], KEY_ROW_n[3]};
        end else begin
            slot_cnt  <= slot_cnt + SLOT_W'(1);
        end
    end

    // Active keys in the current row; the highest column wins as "last found"
    always_comb begin
        row_count = '0;
        row_col   = '0;
        for (int unsigned c = 0; c < 4; c++) begin
            if (!col_sync[c]) begin
                row_count = row_count + 3'd1;
                row_col   = 2'(c);
            end
        end
    end

    // Frame result including the row being sampled this cycle
    always_comb begin
        sum_count  = {1'b0, acc_n} + row_count;
        frame_n    = (sum_count >= 3'd2) ? 2'd2 : sum_count[1:0];
        frame_code = (row_count != 3'd0) ? {row_idx, row_col} : acc_code;
    end

    // Per-frame accumulation, cleared once the frame result is consumed
    always_ff @(posedge clk or negedge sysclr_n) begin
        if (!sysclr_n) begin
            acc_n    <= '0;
            acc_code <= '0;
        end else if (frame_end) begin
            acc_n    <= '0;
            acc_code <= '0;
        end else if (slot_end) begin
            acc_n    <= frame_n;
            acc_code <= frame_code;
        end
    end

    // Debounce FSM: next state and registered-output values, evaluated at frame-end
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        cand_nx  = cand;
        code_nx  = key_code;
        valid_nx = 1'b0;
        held_nx  = key_held;
        if (frame_end) begin
            unique case (state)
                ST_IDLE: begin
                    if (frame_n == 2'd1) begin
                        state_nx = ST_DEBOUNCE;
                        cand_nx  = frame_code;
                        cnt_nx   = CNT_W'(1);
                    end
                end
                ST_DEBOUNCE: begin
                    if (frame_n == 2'd1 && frame_code == cand) begin
                        if (cnt == CNT_LAST) begin
                            state_nx = ST_PRESSED;
                            cnt_nx   = '0;
                            code_nx  = cand;
                            valid_nx = 1'b1;
                            held_nx  = 1'b1;
                        end else begin
                            cnt_nx = cnt + CNT_W'(1);
                        end
                    end else begin
                        state_nx = ST_IDLE;
                        cnt_nx   = '0;
                    end
                end
                ST_PRESSED: begin
                    if (frame_n == 2'd0) begin
                        state_nx = ST_RELEASE;
                        cnt_nx   = CNT_W'(1);
                    end
                end
                ST_RELEASE: begin
                    if (frame_n == 2'd0) begin
                        if (cnt == CNT_LAST) begin
                            state_nx = ST_IDLE;
                            cnt_nx   = '0;
                            held_nx  = 1'b0;
                        end else begin
                            cnt_nx = cnt + CNT_W'(1);
                        end
                    end else begin
                        state_nx = ST_PRESSED;
                        cnt_nx   = '0;
                    end
                end
                default: begin
                    state_nx = ST_IDLE;
                    cnt_nx   = '0;
                end
            endcase
        end
    end

    // FSM state and output registers
    always_ff @(posedge clk or negedge sysclr_n) begin
        if (!sysclr_n) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            cand      <= '0;
            key_code  <= '0;
            key_valid <= 1'b0;
            key_held  <= 1'b0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            cand      <= cand_nx;
            key_code  <= code_nx;
            key_valid <= valid_nx;
            key_held  <= held_nx;
        end
    end

endmodule

// File: tb/tb_key_scan.sv
// tb_key_scan: keypad model around key_scan with table, hand-written and
// randomized frame-level checks against a run-length debounce model.
module tb_key_scan;

    localparam int unsigned SD    = 4;
    localparam int unsigned DF    = 3;
    localparam int          FRAME = 4 * SD;

    logic        clk      = 1'b0;
    logic        sysclr_n = 1'b1;
    logic [3:0]  KEY_COL_n;
    logic [3:0]  KEY_ROW_n;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_held;
    logic [15:0] pressed  = '0;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    typedef struct {
        logic [15:0] keys;
        logic        valid;
        logic [3:0]  code;
        logic        held;
    } frame_vec_t;

    frame_vec_t vecs[$];

    // reference model state (frame-level)
    bit         m_held;
    int         m_streak;
    int         m_quiet;
    int         m_cand;
    logic [3:0] m_code;

    key_scan #(.SCAN_DIV(SD), .DEBOUNCE_FRAMES(DF)) dut (
        .clk       (clk),
        .sysclr_n  (sysclr_n),
        .KEY_COL_n (KEY_COL_n),
        .KEY_ROW_n (KEY_ROW_n),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_held  (key_held)
    );

    always #5 clk = ~clk;

    // keypad: a pressed key pulls its column low while its row is driven low
    always_comb begin
        KEY_COL_n = 4'b1111;
        for (int r = 0; r < 4; r++)
            if (!KEY_ROW_n[r]) KEY_COL_n = KEY_COL_n & ~pressed[r*4 +: 4];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run_steps(input int n, output int np, output int first,
                             output logic [3:0] code_at, output logic held_at);
        np = 0; first = -1; code_at = '0; held_at = 1'b0;
        for (int i = 0; i < n; i++) begin
            step();
            if (key_valid) begin
                np++;
                if (first < 0) begin
                    first   = cyc;
                    code_at = key_code;
                    held_at = key_held;
                end
            end
        end
    endtask

    task automatic do_reset(input logic [15:0] p);
        @(posedge clk);
        #1;
        sysclr_n = 1'b0;
        pressed  = p;
        repeat (2) @(posedge clk);
        #1;
        sysclr_n = 1'b1;
        cyc      = 0;
    endtask

    // one whole frame starting at its first cycle with the given keys held
    task automatic run_frame(input logic [15:0] p, output logic v, output logic [3:0] c,
                             output logic h, output int np);
        pressed = p;
        np = 0;
        for (int i = 0; i < FRAME; i++) begin
            step();
            if (key_valid) np++;
        end
        v = key_valid;
        c = key_code;
        h = key_held;
    endtask

    task automatic add_vec(input logic [15:0] k, input logic v, input logic [3:0] c, input logic h);
        frame_vec_t e;
        e.keys = k; e.valid = v; e.code = c; e.held = h;
        vecs.push_back(e);
    endtask

    function automatic int top_key(input logic [15:0] p);
        top_key = -1;
        for (int i = 0; i < 16; i++) if (p[i]) top_key = i;
    endfunction

    task automatic model_reset();
        m_held = 0; m_streak = 0; m_quiet = 0; m_cand = 0; m_code = '0;
    endtask

    // accept after DF identical single-key frames; release after DF empty frames
    task automatic model_frame(input logic [15:0] p, output bit v);
        int n;
        int k;
        n = $countones(p);
        k = top_key(p);
        v = 0;
        if (!m_held) begin
            if (n == 1) begin
                if (m_streak == 0) begin
                    m_streak = 1;
                    m_cand   = k;
                end else if (k == m_cand) begin
                    m_streak++;
                end else begin
                    m_streak = 0;
                end
            end else begin
                m_streak = 0;
            end
            if (m_streak == DF) begin
                v        = 1;
                m_held   = 1;
                m_code   = 4'(m_cand);
                m_streak = 0;
                m_quiet  = 0;
            end
        end else begin
            if (n == 0) m_quiet++;
            else        m_quiet = 0;
            if (m_quiet == DF) begin
                m_held  = 0;
                m_quiet = 0;
            end
        end
    endtask

    initial begin
        int          np, first;
        logic [3:0]  ca, c, er;
        logic        ha, v, h;
        bit          mv;
        logic [15:0] rk;
        int          a, b;

        // ---------------- reset values, single press, row sequence
        pressed = 16'h0200;
        #2 sysclr_n = 1'b0;
        #1;
        check("rst_row",   KEY_ROW_n, 4'b1110);
        check("rst_code",  key_code,  4'h0);
        check("rst_valid", key_valid, 1'b0);
        check("rst_held",  key_held,  1'b0);
        @(posedge clk);
        #1;
        sysclr_n = 1'b1;
        cyc = 0;
        np = 0; first = -1; ca = '0; ha = 1'b0;
        for (int k = 0; k < 52; k++) begin
            if (k < 16) begin
                er = 4'b0001 << (k / 4);
                er = ~er;
                check($sformatf("row_seq%0d", k), KEY_ROW_n, er);
            end
            step();
            if (key_valid) begin
                np++;
                if (first < 0) begin first = cyc; ca = key_code; ha = key_held; end
            end
        end
        check("press_pulses", np, 1);
        check("press_edge", first, 48);
        check("press_code", ca, 4'h9);
        check("press_held", ha, 1'b1);

        // ---------------- bounce: toggle every 6 cycles for 5 frames, then stable
        do_reset(16'h0000);
        np = 0; first = -1; ca = '0;
        for (int t = 0; t < 150; t++) begin
            if (t < 5 * FRAME) pressed = (((t / 6) % 2) == 1) ? 16'h0200 : 16'h0000;
            else               pressed = 16'h0200;
            step();
            if (key_valid) begin
                np++;
                if (first < 0) begin first = cyc; ca = key_code; end
            end
        end
        check("bounce_pulses", np, 1);
        check("bounce_edge", first, 8 * FRAME);
        check("bounce_code", ca, 4'h9);

        // ---------------- table-driven frame sequence
        add_vec(16'h0020, 0, 4'h0, 0);  // key 5
        add_vec(16'h0020, 0, 4'h0, 0);
        add_vec(16'h0020, 1, 4'h5, 1);
        add_vec(16'h0420, 0, 4'h5, 1);  // add key 10 while held
        add_vec(16'h0420, 0, 4'h5, 1);
        add_vec(16'h0400, 0, 4'h5, 1);
        add_vec(16'h0000, 0, 4'h5, 1);
        add_vec(16'h0000, 0, 4'h5, 1);
        add_vec(16'h0000, 0, 4'h5, 0);
        add_vec(16'h0400, 0, 4'h5, 0);  // fresh press of key 10
        add_vec(16'h0400, 0, 4'h5, 0);
        add_vec(16'h0400, 1, 4'hA, 1);
        add_vec(16'h0000, 0, 4'hA, 1);  // release with one-frame glitch
        add_vec(16'h0400, 0, 4'hA, 1);
        add_vec(16'h0000, 0, 4'hA, 1);
        add_vec(16'h0000, 0, 4'hA, 1);
        add_vec(16'h0000, 0, 4'hA, 0);
        add_vec(16'h8001, 0, 4'hA, 0);  // keys 0 and 15 together
        add_vec(16'h8001, 0, 4'hA, 0);
        add_vec(16'h8001, 0, 4'hA, 0);
        add_vec(16'h0001, 0, 4'hA, 0);
        add_vec(16'h0001, 0, 4'hA, 0);
        add_vec(16'h0001, 1, 4'h0, 1);
        add_vec(16'h0000, 0, 4'h0, 1);
        add_vec(16'h0000, 0, 4'h0, 1);
        add_vec(16'h0000, 0, 4'h0, 0);
        add_vec(16'h0008, 0, 4'h0, 0);  // key 3 then key 4 breaks debounce
        add_vec(16'h0010, 0, 4'h0, 0);
        add_vec(16'h0010, 0, 4'h0, 0);
        add_vec(16'h0010, 0, 4'h0, 0);
        add_vec(16'h0010, 1, 4'h4, 1);
        do_reset(16'h0000);
        foreach (vecs[i]) begin
            run_frame(vecs[i].keys, v, c, h, np);
            check($sformatf("vec%0d_valid", i), v, vecs[i].valid);
            check($sformatf("vec%0d_code", i), c, vecs[i].code);
            check($sformatf("vec%0d_held", i), h, vecs[i].held);
            check($sformatf("vec%0d_pulses", i), np, vecs[i].valid ? 1 : 0);
        end

        // ---------------- async reset while debouncing with cnt = 2
        do_reset(16'h0200);
        for (int f = 0; f < 3; f++) run_frame(16'h0200, v, c, h, np);
        check("ar_accept_code", c, 4'h9);
        for (int f = 0; f < 3; f++) run_frame(16'h0000, v, c, h, np);
        check("ar_released", h, 1'b0);
        for (int f = 0; f < 2; f++) run_frame(16'h0200, v, c, h, np);
        repeat (5) step();
        #2 sysclr_n = 1'b0;
        #1;
        check("ar_row",   KEY_ROW_n, 4'b1110);
        check("ar_code",  key_code,  4'h0);
        check("ar_valid", key_valid, 1'b0);
        check("ar_held",  key_held,  1'b0);
        run_steps(20, np, first, ca, ha);
        check("ar_no_pulse_in_reset", np, 0);
        sysclr_n = 1'b1;
        cyc = 0;
        run_steps(52, np, first, ca, ha);
        check("ar_pulses", np, 1);
        check("ar_edge", first, 48);
        check("ar_code_after", ca, 4'h9);

        // ---------------- randomized frames against the reference model
        do_reset(16'h0000);
        model_reset();
        rk = '0;
        for (int f = 0; f < 100; f++) begin
            a = $urandom_range(0, 9);
            if (a >= 5 && a <= 6) begin
                rk = '0;
            end else if (a >= 7 && a <= 8) begin
                rk = '0;
                rk[$urandom_range(0, 15)] = 1'b1;
            end else if (a == 9) begin
                rk = '0;
                b = $urandom_range(0, 15);
                rk[b] = 1'b1;
                rk[(b + 1 + $urandom_range(0, 14)) % 16] = 1'b1;
            end
            model_frame(rk, mv);
            run_frame(rk, v, c, h, np);
            check($sformatf("rnd%0d_valid", f), v, mv);
            check($sformatf("rnd%0d_code", f), c, m_code);
            check($sformatf("rnd%0d_held", f), h, m_held);
            check($sformatf("rnd%0d_pulses", f), np, mv ? 1 : 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/key_scan.md
# key_scan

Matrix keypad scanner for the elevator panel: the input-side counterpart of the 7-segment display scanner. It drives the rows of a 4x4 active-low key matrix one at a time and samples the columns. Each scan frame is debounced, and every accepted press produces a one-cycle `key_valid` pulse with a 4-bit key code. It sits between the panel pins and the floor-request/control logic, in the same `clk`/`sysclr_n` domain as the display path.

## Interface
- `SCAN_DIV`, 4096: clk cycles per row slot; must be ≥ 4.
- `DEBOUNCE_FRAMES`, 3: consecutive identical frames needed to accept a press or a release; must be ≥ 2.
- `clk`  in  1  system clock.
- `sysclr_n`  in  1  reset, asynchronous, active-low.
- `KEY_COL_n`  in  4  column lines, active-low, externally pulled up, asynchronous to `clk`.
- `KEY_ROW_n`  out  4  row drive, one-hot low.
- `key_code`  out  4  last accepted key, `{row[1:0], col[1:0]}`.
- `key_valid`  out  1  one-cycle pulse on acceptance of a press.
- `key_held`  out  1  high from acceptance until the debounced release.

## Operation
- **Column synchroniser**: two flops on `KEY_COL_n`, reset to `4'b1111`.
- **Slot counter**: counts 0..`SCAN_DIV`-1.
  - On wrap, `KEY_ROW_n` rotates 1110 → 1101 → 1011 → 0111 → 1110.
  - A row-index counter 0..3 tracks the active row.
- **Sampling**: on the last cycle of each slot (slot count = `SCAN_DIV`-1), the synchronised columns are sampled for the active row.
- **Frame**: four slots (rows 0..3). Frame-end is the sample cycle of row 3.
- **Per-frame accumulation**: number of active keys, clamped to 2, plus the code of the last active key found.
  - Scan order is row 0→3; within a row, col 0→3.
  - Accumulators clear on the cycle after frame-end.
- **Frame result**: NONE (0 keys), ONE(code), or MULTI (≥2 keys).
- **FSM**: state is evaluated only at frame-end. `cnt` is the frame counter; `cand` is the candidate code.
  - **IDLE**
    - ONE(c): go to DEBOUNCE with `cand`=c, `cnt`=1.
    - NONE or MULTI: stay.
  - **DEBOUNCE**
    - ONE(c) with c==`cand`: `cnt`++.
    - When `cnt`+1 == `DEBOUNCE_FRAMES`: go to PRESSED. On the same edge, `key_code`<=`cand`, `key_valid`<=1, `key_held`<=1.
    - Any other result: go to IDLE with `cnt`=0.
  - **PRESSED**
    - NONE: go to RELEASE with `cnt`=1.
    - ONE or MULTI: stay. No new pulse is generated, and `key_code` is unchanged even if a second key is added.
  - **RELEASE**
    - NONE: `cnt`++. When `cnt`+1 == `DEBOUNCE_FRAMES`: go to IDLE and set `key_held`<=0.
    - ONE or MULTI: return to PRESSED with `cnt`=0. No pulse.
- **Output holding**:
  - `key_code` holds its value until the next acceptance.
  - `key_valid` is registered and deasserts the following cycle.
- **Counter widths**:
  - `cnt` ≥ clog2(`DEBOUNCE_FRAMES`+1).
  - Slot counter ≥ clog2(`SCAN_DIV`).

## Timing
- **Reset values**: `KEY_ROW_n`=4'b1110, `key_code`=0, `key_valid`=0, `key_held`=0. FSM=IDLE; all counters and accumulators are 0.
- **Reset mid-operation**: everything returns to the reset values immediately (asynchronous). No `key_valid` pulse is generated across reset.
- **Synchroniser latency**: 2 cycles. A column change must be present at least 3 cycles before the sample cycle to be seen in that slot.
- **Frame period**: 4·`SCAN_DIV` cycles. The first frame-end is the cycle in which the counter reads `4·SCAN_DIV-1` after reset release.
- **Press latency**: a key stable from reset release produces `key_valid` on frame-end number `DEBOUNCE_FRAMES`, i.e. edge number `DEBOUNCE_FRAMES·4·SCAN_DIV`.
- **Release latency**: `key_held` falls at frame-end number `DEBOUNCE_FRAMES` counted from the first all-NONE frame.
- **Rate limit**: at most one `key_valid` per press/release cycle.

## Test plan
- **Single press**: `SCAN_DIV`=4, `DEBOUNCE_FRAMES`=3; hold row 2/col 1 pressed from reset release.
  - Required: `key_valid` is a single 1-cycle pulse at edge 48 with `key_code`=4'h9, `key_held`=1.
  - Required: `KEY_ROW_n` sequence 1110, 1101, 1011, 0111 with 4 cycles each.
- **Bounce**: the key toggles every 6 cycles for 5 frames, then stays stable.
  - Required: no pulse during bouncing.
  - Required: exactly one pulse 3 frame-ends after the first fully stable frame.
- **Release debounce**: release after acceptance; re-press for one frame after 1 NONE frame; then release for 3 frames.
  - Required: `key_held` stays 1 through the glitch and falls at the 3rd NONE frame-end.
  - Required: no second `key_valid`.
- **Multi-key**: press keys 0 and 15 together from IDLE.
  - Required: no pulse.
  - Then release key 15: pulse after 3 frames with `key_code`=4'h0.
- **Second key while held**: accept key 5, then add key 10.
  - Required: no pulse, `key_code` stays 5.
  - Required: after full release and a new press of key 10, pulse with `key_code`=4'hA.
- **Async reset mid-debounce**: assert `sysclr_n`=0 while in DEBOUNCE with `cnt`=2.
  - Required: all outputs are at reset values immediately.
  - Required: after release, acceptance needs a full 3 frames again (edge 48).
